// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RISC-V control unit sequencing FETCH/DECODE/EXEC/MEM/WB
// with registered decode, phase-gated strobes, a memory timeout and a sticky trap.
module multicycle_ctrl #(
    parameter bit RV32E   = 1'b0,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid,
    output logic        ifu_ready,
    input  logic [31:0] inst,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic [2:0]  ExtOP,
    output logic        RegWr,
    output logic        ALUAsrc,
    output logic [1:0]  ALUBsrc,
    output logic [3:0]  ALUctr,
    output logic [2:0]  Branch,
    output logic        MemtoReg,
    output logic        MemWr,
    output logic [2:0]  MemOP,
    output logic        pc_wr,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t      r_state, w_next;
    logic [31:0] r_ir;
    logic [7:0]  r_cnt;
    logic [1:0]  r_cause, w_cause;
    logic        r_ld, r_st, r_wr;
    logic [2:0]  r_ext, r_br, r_mop;
    logic        r_asrc, r_m2r;
    logic [1:0]  r_bsrc;
    logic [3:0]  r_ctr;

    logic [6:0]  w_op, w_f7;
    logic [2:0]  w_f3;
    logic [2:0]  w_ext, w_br, w_mop;
    logic        w_asrc, w_m2r, w_ld, w_st, w_wr;
    logic [1:0]  w_bsrc;
    logic [3:0]  w_ctr;
    logic        w_ok, w_use1, w_use2, w_used, w_ebreak, w_legal;

    assign w_op     = r_ir[6:0];
    assign w_f3     = r_ir[14:12];
    assign w_f7     = r_ir[31:25];
    assign w_ebreak = (r_ir == 32'h0010_0073);
    // Under RV32E only the register fields the format actually uses are range-checked
    assign w_legal  = w_ok && !(RV32E && ((w_use1 && r_ir[19]) || (w_use2 && r_ir[24]) ||
                                          (w_used && r_ir[11])));

    always_comb begin
        w_ext  = 3'b000;
        w_asrc = 1'b0;
        w_bsrc = 2'b00;
        w_ctr  = 4'b0000;
        w_br   = 3'b000;
        w_m2r  = 1'b0;
        w_mop  = 3'b000;
        w_ld   = 1'b0;
        w_st   = 1'b0;
        w_wr   = 1'b0;
        w_ok   = 1'b0;
        w_use1 = 1'b0;
        w_use2 = 1'b0;
        w_used = 1'b0;
        case (w_op)
            7'b0010011: if (w_f3 == 3'b000) begin
                w_ok = 1'b1; w_wr = 1'b1; w_use1 = 1'b1; w_used = 1'b1;
                w_bsrc = 2'b01;
            end
            7'b0010111: begin
                w_ok = 1'b1; w_wr = 1'b1; w_used = 1'b1;
                w_ext = 3'b001; w_asrc = 1'b1; w_bsrc = 2'b01;
            end
            7'b0110111: begin
                w_ok = 1'b1; w_wr = 1'b1; w_used = 1'b1;
                w_ext = 3'b001; w_bsrc = 2'b01; w_ctr = 4'b0011;
            end
            7'b1101111: begin
                w_ok = 1'b1; w_wr = 1'b1; w_used = 1'b1;
                w_ext = 3'b100; w_asrc = 1'b1; w_bsrc = 2'b10; w_br = 3'b001;
            end
            7'b1100111: if (w_f3 == 3'b000) begin
                w_ok = 1'b1; w_wr = 1'b1; w_use1 = 1'b1; w_used = 1'b1;
                w_asrc = 1'b1; w_bsrc = 2'b10; w_br = 3'b010;
            end
            7'b0110011: if (w_f3 == 3'b000 && (w_f7 == 7'b0000000 || w_f7 == 7'b0100000)) begin
                w_ok = 1'b1; w_wr = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; w_used = 1'b1;
                w_ctr = {w_f7[5], 3'b000};
            end
            7'b1100011: if (w_f3[2:1] != 2'b01) begin
                w_ok = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1;
                w_ext = 3'b011; w_ctr = 4'b1000; w_br = {1'b1, w_f3[2:1]}; w_mop = w_f3;
            end
            7'b0000011: if (w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
                w_ok = 1'b1; w_ld = 1'b1; w_wr = 1'b1; w_use1 = 1'b1; w_used = 1'b1;
                w_bsrc = 2'b01; w_m2r = 1'b1; w_mop = w_f3;
            end
            7'b0100011: if (w_f3 inside {3'b000, 3'b001, 3'b010}) begin
                w_ok = 1'b1; w_st = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1;
                w_ext = 3'b010; w_bsrc = 2'b01; w_mop = w_f3;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next  = r_state;
        w_cause = r_cause;
        case (r_state)
            S_FETCH:  w_next = inst_valid ? S_DECODE : S_FETCH;
            S_DECODE: begin
                w_next  = (w_ebreak || !w_legal) ? S_TRAP : S_EXEC;
                w_cause = w_ebreak ? 2'b00 : (w_legal ? r_cause : 2'b01);
            end
            S_EXEC:   w_next = (r_ld || r_st) ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ack) begin
                    w_next = r_st ? S_FETCH : S_WB;
                end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                    w_next  = S_TRAP;
                    w_cause = 2'b10;
                end
            end
            S_WB:     w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_ir    <= 32'h0;
            r_cnt   <= 8'h0;
            r_cause <= 2'b00;
            r_ld    <= 1'b0;
            r_st    <= 1'b0;
            r_wr    <= 1'b0;
            r_ext   <= 3'b000;
            r_asrc  <= 1'b0;
            r_bsrc  <= 2'b00;
            r_ctr   <= 4'b0000;
            r_br    <= 3'b000;
            r_m2r   <= 1'b0;
            r_mop   <= 3'b000;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause;
            r_cnt   <= (r_state == S_MEM && !mem_ack) ? r_cnt + 8'd1 : 8'h0;
            if (r_state == S_FETCH && inst_valid)
                r_ir <= inst;
            if (r_state == S_DECODE) begin
                r_ld   <= w_ld;
                r_st   <= w_st;
                r_wr   <= w_wr;
                r_ext  <= w_ext;
                r_asrc <= w_asrc;
                r_bsrc <= w_bsrc;
                r_ctr  <= w_ctr;
                r_br   <= w_br;
                r_m2r  <= w_m2r;
                r_mop  <= w_mop;
            end
        end
    end

    assign ifu_ready  = (r_state == S_FETCH);
    assign mem_req    = (r_state == S_MEM);
    assign MemWr      = (r_state == S_MEM) && r_st;
    assign RegWr      = (r_state == S_WB) && r_wr;
    assign pc_wr      = (r_state == S_WB) || ((r_state == S_MEM) && r_st && mem_ack);
    assign trap       = (r_state == S_TRAP);
    assign trap_cause = r_cause;
    assign ExtOP      = r_ext;
    assign ALUAsrc    = r_asrc;
    assign ALUBsrc    = r_bsrc;
    assign ALUctr     = r_ctr;
    assign Branch     = r_br;
    assign MemtoReg   = r_m2r;
    assign MemOP      = r_mop;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and random instructions checked against an
// instruction-level reference model of the multicycle controller.
module tb_multicycle_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0, rst_n = 1'b0, inst_valid = 1'b0, mem_ack = 1'b0;
    logic [31:0] inst = 32'h0;
    logic        ifu_ready, mem_req, RegWr, ALUAsrc, MemtoReg, MemWr, pc_wr, trap;
    logic [2:0]  ExtOP, Branch, MemOP;
    logic [1:0]  ALUBsrc, trap_cause;
    logic [3:0]  ALUctr;

    int n_chk = 0, n_err = 0;

    multicycle_ctrl #(.RV32E(1'b1), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .ifu_ready(ifu_ready),
        .inst(inst), .mem_ack(mem_ack), .mem_req(mem_req), .ExtOP(ExtOP),
        .RegWr(RegWr), .ALUAsrc(ALUAsrc), .ALUBsrc(ALUBsrc), .ALUctr(ALUctr),
        .Branch(Branch), .MemtoReg(MemtoReg), .MemWr(MemWr), .MemOP(MemOP),
        .pc_wr(pc_wr), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] kind;   // 0 legal, 1 ebreak, 2 illegal
        logic       ld, st, wr;
        logic [2:0] ext;
        logic       asrc;
        logic [1:0] bsrc;
        logic [3:0] ctr;
        logic [2:0] br;
        logic       m2r;
        logic [2:0] mop;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instruction-level meaning: pick the mnemonic, then its format's register usage
    function automatic exp_t model(input logic [31:0] x);
        exp_t       e = '0;
        logic [2:0] f3 = x[14:12];
        logic [6:0] f7 = x[31:25];
        bit         ok = 1'b0, u1 = 1'b0, u2 = 1'b0, ud = 1'b0;
        e.kind = 2'd2;
        if (x == 32'h00100073) begin
            e.kind = 2'd1;
            return e;
        end
        case (x[6:0])
            7'h13: if (f3 == 0) begin ok = 1; u1 = 1; ud = 1; e.wr = 1; e.bsrc = 1; end
            7'h17: begin ok = 1; ud = 1; e.wr = 1; e.ext = 1; e.asrc = 1; e.bsrc = 1; end
            7'h37: begin ok = 1; ud = 1; e.wr = 1; e.ext = 1; e.bsrc = 1; e.ctr = 4'd3; end
            7'h6f: begin ok = 1; ud = 1; e.wr = 1; e.ext = 4; e.asrc = 1; e.bsrc = 2; e.br = 1; end
            7'h67: if (f3 == 0) begin
                ok = 1; u1 = 1; ud = 1; e.wr = 1; e.asrc = 1; e.bsrc = 2; e.br = 2;
            end
            7'h33: if (f3 == 0 && (f7 == 0 || f7 == 7'h20)) begin
                ok = 1; u1 = 1; u2 = 1; ud = 1; e.wr = 1; e.ctr = (f7 == 7'h20) ? 4'd8 : 4'd0;
            end
            7'h63: if (f3 != 2 && f3 != 3) begin
                ok = 1; u1 = 1; u2 = 1; e.ext = 3; e.ctr = 4'd8; e.br = 3'(4 + f3 / 2); e.mop = f3;
            end
            7'h03: if (f3 != 3 && f3 < 6) begin
                ok = 1; u1 = 1; ud = 1; e.ld = 1; e.wr = 1; e.bsrc = 1; e.m2r = 1; e.mop = f3;
            end
            7'h23: if (f3 < 3) begin
                ok = 1; u1 = 1; u2 = 1; e.st = 1; e.ext = 2; e.bsrc = 1; e.mop = f3;
            end
            default: ;
        endcase
        if (ok && !((u1 && x[19:15] >= 16) || (u2 && x[24:20] >= 16) || (ud && x[11:7] >= 16)))
            e.kind = 2'd0;
        return e;
    endfunction

    function automatic logic [4:0] rnd_reg();
        return ($urandom_range(0, 7) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] r = $urandom;
        logic [4:0]  rd = rnd_reg(), rs1 = rnd_reg(), rs2 = rnd_reg();
        logic [2:0]  f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 11))
            0:  return {r[31:20], rs1, 3'b000, rd, 7'h13};
            1:  return {r[31:12], rd, 7'h17};
            2:  return {r[31:12], rd, 7'h37};
            3:  return {r[31:12], rd, 7'h6f};
            4:  return {r[31:20], rs1, 3'b000, rd, 7'h67};
            5:  return {r[0] ? 7'h20 : 7'h00, rs2, rs1, 3'b000, rd, 7'h33};
            6:  return {r[31:25], rs2, rs1, f3, r[11:7], 7'h63};
            7:  return {r[31:20], rs1, f3, rd, 7'h03};
            8:  return {r[31:25], rs2, rs1, f3, r[11:7], 7'h23};
            9:  return 32'h00100073;
            10: return r;
            default: return {r[31:25], rs2, rs1, 3'($urandom_range(0, 2)), r[11:7], 7'h23};
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
        inst_valid = 1'($urandom);
        inst       = $urandom;
        mem_ack    = 1'($urandom);
    endtask

    task automatic strobes(input string tag, input logic rw, input logic pw, input logic mr,
                           input logic mw);
        check({tag, "_RegWr"}, 32'(RegWr), 32'(rw));
        check({tag, "_pc_wr"}, 32'(pc_wr), 32'(pw));
        check({tag, "_mem_req"}, 32'(mem_req), 32'(mr));
        check({tag, "_MemWr"}, 32'(MemWr), 32'(mw));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; inst_valid = 1'b0; mem_ack = 1'b0;
        #1;
        check("rst_ifu_ready", 32'(ifu_ready), 32'd1);
        check("rst_outputs", 32'({RegWr, ALUAsrc, ALUBsrc, ALUctr, Branch, MemtoReg, MemWr, MemOP,
                                  pc_wr, trap, trap_cause, mem_req, ExtOP}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // d = MEM cycle on which mem_ack rises; 0 or > TO means never
    task automatic run_inst(input logic [31:0] ins, input int d);
        exp_t e = model(ins);
        bit   acked = 1'b0;
        @(negedge clk);
        inst_valid = 1'b1; inst = ins; mem_ack = 1'($urandom);
        #1;
        check("fetch_ready", 32'(ifu_ready), 32'd1);
        check("fetch_trap", 32'(trap), 32'd0);
        strobes("fetch", 0, 0, 0, 0);
        tick(); #1;
        check("decode_ready", 32'(ifu_ready), 32'd0);
        strobes("decode", 0, 0, 0, 0);
        tick(); #1;
        if (e.kind != 0) begin
            check("trap", 32'(trap), 32'd1);
            check("trap_cause", 32'(trap_cause), (e.kind == 1) ? 32'd0 : 32'd1);
            for (int i = 0; i < 3; i++) begin
                tick(); inst_valid = 1'b1; #1;
                check("trap_hold", 32'({trap, trap_cause, ifu_ready}),
                      32'({1'b1, (e.kind == 1) ? 2'b00 : 2'b01, 1'b0}));
                strobes("trap", 0, 0, 0, 0);
            end
            do_reset();
            return;
        end
        check("trap_clear", 32'(trap), 32'd0);
        check("ExtOP", 32'(ExtOP), 32'(e.ext));
        check("ALUAsrc", 32'(ALUAsrc), 32'(e.asrc));
        check("ALUBsrc", 32'(ALUBsrc), 32'(e.bsrc));
        check("ALUctr", 32'(ALUctr), 32'(e.ctr));
        check("Branch", 32'(Branch), 32'(e.br));
        check("MemtoReg", 32'(MemtoReg), 32'(e.m2r));
        check("MemOP", 32'(MemOP), 32'(e.mop));
        strobes("exec", 0, 0, 0, 0);
        if (!(e.ld || e.st)) begin
            tick(); #1;
            strobes("wb", e.wr, 1, 0, 0);
            check("wb_hold", 32'({ExtOP, ALUctr, Branch}), 32'({e.ext, e.ctr, e.br}));
            return;
        end
        for (int k = 1; k <= TO && !acked; k++) begin
            tick(); mem_ack = (k == d); #1;
            strobes("mem", 0, e.st && k == d, 1, e.st);
            check("mem_MemOP", 32'(MemOP), 32'(e.mop));
            acked = (k == d);
        end
        if (!acked) begin
            tick(); #1;
            check("timeout_trap", 32'({trap, trap_cause}), 32'({1'b1, 2'b10}));
            strobes("timeout", 0, 0, 0, 0);
            do_reset();
            return;
        end
        if (e.ld) begin
            tick(); #1;
            strobes("ld_wb", 1, 1, 0, 0);
            check("ld_MemtoReg", 32'(MemtoReg), 32'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        // asynchronous reset while a load waits in MEM
        @(negedge clk); inst_valid = 1'b1; inst = 32'h00012183;
        repeat (2) begin @(negedge clk); inst_valid = 1'b0; end
        @(negedge clk); mem_ack = 1'b0; #1;
        check("mid_mem_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0; #1;
        check("async_mem_req", 32'(mem_req), 32'd0);
        check("async_ifu_ready", 32'(ifu_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1; #1;
        check("post_rst_ready", 32'(ifu_ready), 32'd1);
        @(negedge clk); #1;
        check("post_rst_ready2", 32'({ifu_ready, mem_req}), 32'b10);

        run_inst(32'h00500093, 0);
        run_inst(32'h00012183, 3);
        run_inst(32'h00112023, 1);
        run_inst(32'h00112023, 0);
        run_inst(32'h00112023, TO);
        run_inst(32'h00100813, 0);
        run_inst(32'h00100073, 0);

        for (int n = 0; n < 80; n++)
            run_inst(gen_inst(), ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TO));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
